// File: rtl/weight_loader_mb_if.sv
// Bus bundle for the multi-bank weight loader: config handshake, weight
// stream, bank read port and load status. The loader takes the slave view,
// the controller/DMA/PE side takes the master view.
interface weight_loader_mb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int NUM_BANKS  = 4,
  parameter int LEN_WIDTH  = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NUM_BANKS);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [BW-1:0]         cfg_bank;
  logic [AW-1:0]         cfg_addr;
  logic [LEN_WIDTH-1:0]  cfg_length;

  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tlast;

  logic                  rd_en;
  logic [BW-1:0]         rd_bank;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  busy;
  logic                  done;
  logic [LEN_WIDTH-1:0]  weights_loaded;
  logic                  error;
  logic [1:0]            error_code;

  modport master (
    output cfg_valid, cfg_bank, cfg_addr, cfg_length,
    output s_tvalid, s_tdata, s_tlast,
    output rd_en, rd_bank, rd_addr,
    input  cfg_ready, s_tready, rd_data,
    input  busy, done, weights_loaded, error, error_code
  );

  modport slave (
    input  cfg_valid, cfg_bank, cfg_addr, cfg_length,
    input  s_tvalid, s_tdata, s_tlast,
    input  rd_en, rd_bank, rd_addr,
    output cfg_ready, s_tready, rd_data,
    output busy, done, weights_loaded, error, error_code
  );
endinterface

// File: rtl/weight_loader_mb.sv
// Multi-bank weight loader. Accepts a (bank, addr, length) config, streams
// that many weight beats into the selected bank with TLAST framing checks,
// and serves a registered read-first read port into any bank at all times.
module weight_loader_mb #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int NUM_BANKS  = 4,
  parameter int LEN_WIDTH  = 16
) (
  input logic              clk,
  input logic              reset_n,
  weight_loader_mb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t               state_reg;
  logic [BW-1:0]        bank_reg;
  logic [AW-1:0]        addr_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] loaded_reg;
  logic                 cfg_ready_reg;
  logic                 s_tready_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 error_reg;
  logic [1:0]           code_reg;

  logic                 beat;
  logic                 last_beat;
  logic                 cfg_bad;
  logic [LEN_WIDTH:0]   cfg_end;

  // s_tready is only ever high in LOAD, so a handshake is also the write strobe
  assign beat      = bus.s_tvalid && s_tready_reg;
  assign last_beat = (loaded_reg + LEN_WIDTH'(1)) == len_reg;

  // End address is formed one bit wider so a burst ending exactly at DEPTH is legal
  assign cfg_end = (LEN_WIDTH+1)'(bus.cfg_addr) + (LEN_WIDTH+1)'(bus.cfg_length);
  assign cfg_bad = (bus.cfg_length == '0) ||
                   (cfg_end > (LEN_WIDTH+1)'(DEPTH)) ||
                   ({1'b0, bus.cfg_bank} >= (BW+1)'(NUM_BANKS));

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bank_reg      <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      loaded_reg    <= '0;
      cfg_ready_reg <= 1'b1;
      s_tready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      code_reg      <= 2'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cfg_valid && cfg_ready_reg) begin
            loaded_reg <= '0;
            if (cfg_bad) begin
              error_reg <= 1'b1;
              code_reg  <= 2'd1;
            end else begin
              error_reg     <= 1'b0;
              code_reg      <= 2'd0;
              bank_reg      <= bus.cfg_bank;
              addr_reg      <= bus.cfg_addr;
              len_reg       <= bus.cfg_length;
              state_reg     <= LOAD;
              cfg_ready_reg <= 1'b0;
              s_tready_reg  <= 1'b1;
              busy_reg      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            loaded_reg <= loaded_reg + LEN_WIDTH'(1);
            addr_reg   <= addr_reg + AW'(1);
            if (last_beat || bus.s_tlast) begin
              state_reg    <= DONE;
              s_tready_reg <= 1'b0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
              if (!last_beat) begin
                error_reg <= 1'b1;
                code_reg  <= 2'd2;
              end else if (!bus.s_tlast) begin
                error_reg <= 1'b1;
                code_reg  <= 2'd3;
              end
            end
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          cfg_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= IDLE;
          cfg_ready_reg <= 1'b1;
          s_tready_reg  <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  // Per-bank registered read outputs, muxed by the bank captured with the read
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rd;
  logic [BW-1:0]                        rd_bank_reg;
  logic                                 rd_seen_reg;

  // Remember which bank the last read targeted; rd_data reads as zero until the first read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank_reg <= '0;
      rd_seen_reg <= 1'b0;
    end else if (bus.rd_en) begin
      rd_bank_reg <= bus.rd_bank;
      rd_seen_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] q_reg;

      // Single-port-per-direction bank; non-blocking read gives old data on a same-address write
      always_ff @(posedge clk) begin
        if (beat && (bank_reg == BW'(gi))) mem[addr_reg] <= bus.s_tdata;
        if (bus.rd_en && (bus.rd_bank == BW'(gi))) q_reg <= mem[bus.rd_addr];
      end

      assign bank_rd[gi] = q_reg;
    end
  endgenerate

  assign bus.rd_data        = rd_seen_reg ? bank_rd[rd_bank_reg] : '0;
  assign bus.cfg_ready      = cfg_ready_reg;
  assign bus.s_tready       = s_tready_reg;
  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.weights_loaded = loaded_reg;
  assign bus.error          = error_reg;
  assign bus.error_code     = code_reg;
endmodule
